// File: rtl/plot_pkg.sv
// Shared definitions for the plotter motion sequencer.
//   plot_state_e : sequencer states (IDLE, PEN, SETUP, STEP, DONE)
//   DIR_POS/NEG  : value driven on x_dir / y_dir for each direction
//   PEN_UP/DOWN  : value driven on pen_down for each servo position
package plot_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PEN   = 3'd1,
    SETUP = 3'd2,
    STEP  = 3'd3,
    DONE  = 3'd4
  } plot_state_e;

  localparam logic DIR_POS  = 1'b0;
  localparam logic DIR_NEG  = 1'b1;

  localparam logic PEN_UP   = 1'b0;
  localparam logic PEN_DOWN = 1'b1;

endpackage

// File: rtl/step_timer.sv
// Step-period timer shared by both axes.
// A STEP_DIV-cycle counter that restarts from zero the cycle after start.
//   clock, reset_n : clock and asynchronous active-low reset
//   start          : restart request (counter is 0 on the following cycle)
//   pulse_hi       : high during the first floor(STEP_DIV/2) cycles of a period
//   pulse_rise     : high on the first cycle of each period
//   period_end     : high on the last cycle of each period
module step_timer #(
  parameter int unsigned STEP_DIV = 100000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start,
  output logic pulse_hi,
  output logic pulse_rise,
  output logic period_end
);

  localparam int unsigned    TW   = $clog2(STEP_DIV);
  localparam logic [TW-1:0]  LAST = TW'(STEP_DIV - 1);
  localparam logic [TW-1:0]  HALF = TW'(STEP_DIV / 2);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    if (start || (cnt_q == LAST)) cnt_d = '0;
    else                          cnt_d = cnt_q + TW'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign pulse_hi   = (cnt_q < HALF);
  assign pulse_rise = (cnt_q == '0);
  assign period_end = (cnt_q == LAST);

endmodule

// File: rtl/plot_move_sequencer.sv
// Command-level pen plotter motion controller.
// Accepts one relative move (dx, dy, pen) per handshake, optionally waits for
// the pen servo to settle, then drives X/Y step pulses with a Bresenham
// interpolator and tracks absolute position.
// Optional feature: define PLOT_PEN_SETTLE_EN to insert the PEN settle state
// on every pen change; without it PEN_SETTLE is unused.
// Ports:
//   clock, reset_n          : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     : command handshake (ready only in IDLE)
//   cmd_dx, cmd_dy, cmd_pen : signed deltas and pen state (1 = down)
//   abort                   : cancel current command (PEN/SETUP/STEP)
//   pos_clear               : zero position counters (wins over steps)
//   x_step, y_step          : step pulses
//   x_dir, y_dir            : 1 = negative direction
//   pen_down                : servo request
//   pos_x, pos_y            : signed absolute position
//   busy, done              : activity flag, completion pulse
module plot_move_sequencer
  import plot_pkg::*;
#(
  parameter int unsigned STEP_DIV   = 100000,
  parameter int unsigned PEN_SETTLE = 25000000,
  parameter int unsigned CW         = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic signed [CW-1:0] cmd_dx,
  input  logic signed [CW-1:0] cmd_dy,
  input  logic                 cmd_pen,
  input  logic                 abort,
  input  logic                 pos_clear,
  output logic                 x_step,
  output logic                 y_step,
  output logic                 x_dir,
  output logic                 y_dir,
  output logic                 pen_down,
  output logic signed [31:0]   pos_x,
  output logic signed [31:0]   pos_y,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned EW = CW + 2;

  plot_state_e          state_q;
  logic signed [CW-1:0] dx_q, dy_q;
  logic [CW-1:0]        major_q, minor_q, rem_q;
  logic                 major_x_q, minor_mv_q;
  logic signed [EW-1:0] err_q;
  logic                 x_dir_q, y_dir_q, pen_q;
  logic signed [31:0]   pos_x_q, pos_y_q;

`ifdef PLOT_PEN_SETTLE_EN
  localparam int unsigned SW = (PEN_SETTLE > 1) ? $clog2(PEN_SETTLE) : 1;
  logic [SW-1:0] settle_q;
`endif

  logic [CW-1:0]        adx_d, ady_d, major_d, minor_d;
  logic                 major_x_d;
  logic signed [EW-1:0] err0_d;
  logic                 pulse_hi, pulse_rise, period_end;
  logic                 stepping, x_mv, y_mv;

  // Magnitude as CW-bit unsigned; the most negative input maps to 2^(CW-1).
  function automatic logic [CW-1:0] abs_cw(input logic signed [CW-1:0] v);
    logic [CW-1:0] u;
    u = v;
    return v[CW-1] ? (~u + CW'(1)) : u;
  endfunction

  function automatic logic signed [EW-1:0] twice(input logic [CW-1:0] v);
    return $signed({1'b0, v, 1'b0});
  endfunction

  function automatic logic err_pos(input logic signed [EW-1:0] e);
    return !e[EW-1] && (e != '0);
  endfunction

  // One Bresenham update: subtract 2*major when the minor axis steps,
  // then add 2*minor.
  function automatic logic signed [EW-1:0] err_step(input logic signed [EW-1:0] e,
                                                    input logic [CW-1:0]        maj,
                                                    input logic [CW-1:0]        mnr);
    logic signed [EW-1:0] t;
    t = err_pos(e) ? (e - twice(maj)) : e;
    return t + twice(mnr);
  endfunction

  always_comb begin
    adx_d     = abs_cw(dx_q);
    ady_d     = abs_cw(dy_q);
    major_x_d = (adx_d >= ady_d);
    major_d   = major_x_d ? adx_d : ady_d;
    minor_d   = major_x_d ? ady_d : adx_d;
    err0_d    = twice(minor_d) - $signed({2'b00, major_d});
  end

  step_timer #(
    .STEP_DIV (STEP_DIV)
  ) u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (state_q == SETUP),
    .pulse_hi   (pulse_hi),
    .pulse_rise (pulse_rise),
    .period_end (period_end)
  );

  // minor_mv_q holds the minor-axis decision for the current period; it is
  // computed one period ahead so the pulse can rise on the period's first cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      dx_q       <= '0;
      dy_q       <= '0;
      pen_q      <= PEN_UP;
      major_q    <= '0;
      minor_q    <= '0;
      rem_q      <= '0;
      major_x_q  <= 1'b0;
      minor_mv_q <= 1'b0;
      err_q      <= '0;
      x_dir_q    <= DIR_POS;
      y_dir_q    <= DIR_POS;
`ifdef PLOT_PEN_SETTLE_EN
      settle_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            dx_q  <= cmd_dx;
            dy_q  <= cmd_dy;
            pen_q <= cmd_pen;
`ifdef PLOT_PEN_SETTLE_EN
            if (cmd_pen != pen_q) begin
              state_q  <= PEN;
              settle_q <= SW'(PEN_SETTLE - 1);
            end else begin
              state_q  <= SETUP;
            end
`else
            state_q <= SETUP;
`endif
          end
        end
`ifdef PLOT_PEN_SETTLE_EN
        PEN: begin
          if (abort)                 state_q  <= IDLE;
          else if (settle_q == '0)   state_q  <= SETUP;
          else                       settle_q <= settle_q - SW'(1);
        end
`endif
        SETUP: begin
          if (abort) begin
            state_q <= IDLE;
          end else begin
            major_q    <= major_d;
            minor_q    <= minor_d;
            major_x_q  <= major_x_d;
            rem_q      <= major_d;
            minor_mv_q <= err_pos(err0_d);
            err_q      <= err_step(err0_d, major_d, minor_d);
            x_dir_q    <= dx_q[CW-1] ? DIR_NEG : DIR_POS;
            y_dir_q    <= dy_q[CW-1] ? DIR_NEG : DIR_POS;
            state_q    <= (major_d == '0) ? DONE : STEP;
          end
        end
        STEP: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (period_end) begin
            if (rem_q == CW'(1)) begin
              state_q <= DONE;
            end else begin
              rem_q      <= rem_q - CW'(1);
              minor_mv_q <= err_pos(err_q);
              err_q      <= err_step(err_q, major_q, minor_q);
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stepping = (state_q == STEP);
  assign x_mv     = major_x_q | minor_mv_q;
  assign y_mv     = ~major_x_q | minor_mv_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pos_x_q <= '0;
      pos_y_q <= '0;
    end else if (pos_clear) begin
      pos_x_q <= '0;
      pos_y_q <= '0;
    end else begin
      if (stepping && pulse_rise && x_mv)
        pos_x_q <= (x_dir_q == DIR_NEG) ? pos_x_q - 32'sd1 : pos_x_q + 32'sd1;
      if (stepping && pulse_rise && y_mv)
        pos_y_q <= (y_dir_q == DIR_NEG) ? pos_y_q - 32'sd1 : pos_y_q + 32'sd1;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = (state_q == DONE);
  assign x_step    = stepping & pulse_hi & x_mv;
  assign y_step    = stepping & pulse_hi & y_mv;
  assign x_dir     = x_dir_q;
  assign y_dir     = y_dir_q;
  assign pen_down  = pen_q;
  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;

endmodule

// File: tb/tb_plot_move_sequencer.sv
module tb_plot_move_sequencer;

  localparam int SD = 4;
  localparam int PS = 8;
  localparam int CW = 6;

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 cmd_valid = 1'b0;
  logic                 cmd_ready;
  logic signed [CW-1:0] cmd_dx = '0;
  logic signed [CW-1:0] cmd_dy = '0;
  logic                 cmd_pen = 1'b0;
  logic                 abort = 1'b0;
  logic                 pos_clear = 1'b0;
  logic                 x_step, y_step, x_dir, y_dir, pen_down, busy, done;
  logic signed [31:0]   pos_x, pos_y;

  plot_move_sequencer #(
    .STEP_DIV   (SD),
    .PEN_SETTLE (PS),
    .CW         (CW)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dx    (cmd_dx),
    .cmd_dy    (cmd_dy),
    .cmd_pen   (cmd_pen),
    .abort     (abort),
    .pos_clear (pos_clear),
    .x_step    (x_step),
    .y_step    (y_step),
    .x_dir     (x_dir),
    .y_dir     (y_dir),
    .pen_down  (pen_down),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit is_done;
    bit xs, ys, xd, yd, pen;
    int px, py;
    int when;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  failures = 0;

  // Reference model state
  int  mx = 0, my = 0;
  bit  mpen = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic goto(input int target);
    if (cyc > target) begin
      chk("goto_target", cyc, target);
    end
    while (cyc < target) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!cmd_ready && n < 3000) begin
      @(posedge clock); #1;
      n++;
    end
    if (!cmd_ready) begin
      chk("ready_timeout", cmd_ready, 1);
      finish_run();
    end
  endtask

  // Issue one command and push the expected responses. lim >= 0 means the
  // command is cut short after lim steps (no done expected).
  task automatic issue(input int dx, input int dy, input bit pen, input int lim,
                       input int clear_at, output int t0, output int base);
    int adx, ady, maj, mnr, settle, steps, mprev, mk;
    bit majx, mstep;
    ev_t e;
    wait_ready();
    cmd_dx    = CW'(dx);
    cmd_dy    = CW'(dy);
    cmd_pen   = pen;
    cmd_valid = 1'b1;
    t0 = cyc;
`ifdef PLOT_PEN_SETTLE_EN
    settle = (pen != mpen) ? PS : 0;
`else
    settle = 0;
`endif
    base = t0 + 2 + settle;
    adx  = (dx < 0) ? -dx : dx;
    ady  = (dy < 0) ? -dy : dy;
    majx = (adx >= ady);
    maj  = majx ? adx : ady;
    mnr  = majx ? ady : adx;
    steps = (lim >= 0) ? lim : maj;
    mprev = 0;
    for (int k = 1; k <= steps; k++) begin
      // Minor coordinate after k major steps: k*mnr/maj, halves rounded down.
      mk    = (2 * k * mnr + maj - 1) / (2 * maj);
      mstep = (mk != mprev);
      mprev = mk;
      e = '{is_done: 1'b0, xs: 1'b0, ys: 1'b0, xd: (dx < 0), yd: (dy < 0),
            pen: pen, px: 0, py: 0, when: base + (k - 1) * SD};
      e.xs = majx ? 1'b1 : mstep;
      e.ys = majx ? mstep : 1'b1;
      if (e.xs) mx += (dx < 0) ? -1 : 1;
      if (e.ys) my += (dy < 0) ? -1 : 1;
      if (k == clear_at) begin
        mx = 0;
        my = 0;
      end
      e.px = mx;
      e.py = my;
      q.push_back(e);
    end
    mpen = pen;
    if (lim < 0) begin
      e = '{is_done: 1'b1, xs: 1'b0, ys: 1'b0, xd: 1'b0, yd: 1'b0,
            pen: pen, px: mx, py: my, when: base + maj * SD};
      q.push_back(e);
    end
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    cmd_dx    = CW'($urandom);
    cmd_dy    = CW'($urandom);
    cmd_pen   = 1'($urandom);
    chk("pen_down_t1", pen_down, pen);
  endtask

  // Monitor / scoreboard
  bit  prev_any = 1'b0;
  int  hi_cnt = 0;
  bit  pos_pend = 1'b0;
  int  epx, epy;
  ev_t me;

  always @(negedge clock) begin
    if (!reset_n) begin
      prev_any = 1'b0;
      hi_cnt   = 0;
      pos_pend = 1'b0;
    end else begin
      if (pos_pend) begin
        chk("step_pos_x", pos_x, epx);
        chk("step_pos_y", pos_y, epy);
        pos_pend = 1'b0;
      end
      if ((x_step || y_step) && !prev_any) begin
        if (q.size() == 0 || q[0].is_done) begin
          chk("unexpected_step", {x_step, y_step}, 0);
        end else begin
          me = q.pop_front();
          chk("step_cycle", cyc, me.when);
          chk("x_step", x_step, me.xs);
          chk("y_step", y_step, me.ys);
          chk("x_dir", x_dir, me.xd);
          chk("y_dir", y_dir, me.yd);
          epx = me.px;
          epy = me.py;
          pos_pend = 1'b1;
        end
        hi_cnt = 1;
      end else if (x_step || y_step) begin
        hi_cnt++;
      end else if (prev_any) begin
        chk("pulse_width", hi_cnt, SD / 2);
        hi_cnt = 0;
      end
      prev_any = x_step || y_step;
      if (done) begin
        if (q.size() == 0 || !q[0].is_done) begin
          chk("unexpected_done", done, 0);
        end else begin
          me = q.pop_front();
          chk("done_cycle", cyc, me.when);
          chk("done_pos_x", pos_x, me.px);
          chk("done_pos_y", pos_y, me.py);
          chk("done_pen", pen_down, me.pen);
          chk("done_busy", busy, 0);
          chk("done_ready", cmd_ready, 0);
        end
      end
    end
  end

  initial begin
    #500000;
    chk("watchdog", cyc, 0);
    finish_run();
  end

  initial begin
    int t, b, dx, dy, gap;
    bit pen;

    // Reset state
    #2;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_steps", {x_step, y_step}, 0);
    chk("rst_pos_x", pos_x, 0);
    chk("rst_misc", {x_dir, y_dir, pen_down, busy, done}, 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;

    // Pure X move
    issue(3, 0, 1'b0, -1, -1, t, b);
    // Diagonal move
    issue(-4, 2, 1'b0, -1, -1, t, b);
    // Pen-only command
    issue(0, 0, 1'b1, -1, -1, t, b);

    // Abort after the third step rise
    issue(10, 0, 1'b1, 3, -1, t, b);
    goto(b + 2 * SD + 1);
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    chk("abort_steps_low", {x_step, y_step}, 0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_pos_x", pos_x, mx);
    chk("abort_pen", pen_down, 1);
    repeat (SD * 3) @(posedge clock);
    #1;

    // Clear in idle, then collision with the 6th step rise
    pos_clear = 1'b1;
    @(posedge clock); #1;
    pos_clear = 1'b0;
    mx = 0;
    my = 0;
    chk("clear_idle_x", pos_x, 0);
    chk("clear_idle_y", pos_y, 0);
    issue(7, 0, mpen, -1, 6, t, b);
    goto(b + 5 * SD);
    pos_clear = 1'b1;
    @(posedge clock); #1;
    pos_clear = 1'b0;

    // Extreme magnitude
    issue(-32, 31, 1'b0, -1, -1, t, b);
    issue(31, -32, 1'b1, -1, -1, t, b);

    // Randomized commands
    for (int i = 0; i < 25; i++) begin
      dx  = int'($urandom_range(63)) - 32;
      dy  = int'($urandom_range(63)) - 32;
      if ($urandom_range(3) == 0) dx = int'($urandom_range(6)) - 3;
      pen = 1'($urandom);
      issue(dx, dy, pen, -1, -1, t, b);
      gap = int'($urandom_range(3));
      repeat (gap) @(posedge clock);
      #1;
    end

    // Reset mid-move
    issue(-20, 5, ~mpen, -1, -1, t, b);
    goto(b + 5);
    reset_n = 1'b0;
    #1;
    chk("arst_steps", {x_step, y_step}, 0);
    chk("arst_dirs", {x_dir, y_dir}, 0);
    chk("arst_pen", pen_down, 0);
    chk("arst_pos_x", pos_x, 0);
    chk("arst_pos_y", pos_y, 0);
    chk("arst_busy_done", {busy, done}, 0);
    chk("arst_ready", cmd_ready, 1);
    q.delete();
    mx = 0;
    my = 0;
    mpen = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_pos_x", pos_x, 0);

    issue(2, -3, 1'b0, -1, -1, t, b);

    for (int n = 0; n < 3000 && q.size() != 0; n++) begin
      @(posedge clock); #1;
    end
    chk("queue_drained", q.size(), 0);
    repeat (4) @(posedge clock);
    #1;
    finish_run();
  end

endmodule

// File: doc/plot_move_sequencer.md
# plot_move_sequencer

Command-level motion controller for the pen plotter. Accepts one relative move (dx, dy, pen state) per handshake and sequences the X/Y stepper drivers with a Bresenham interpolator so diagonal lines are straight. It applies a pen-settle delay before moving and tracks absolute position. It sits between the processor's motion registers and the stepper/servo output stage, replacing direct speed/direction register driving.

## Interface
- `STEP_DIV`, default 100000: clock cycles per step period (1 kHz at 100 MHz); ≥ 2.
- `PEN_SETTLE`, default 25000000: cycles to wait after a pen change (250 ms); ≥ 1.
- `CW`, default 16: width of the signed `cmd_dx` and `cmd_dy` inputs.
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_dx` in CW: signed X delta; positive = right.
- `cmd_dy` in CW: signed Y delta; positive = down.
- `cmd_pen` in 1: pen state for this move; 1 = down.
- `abort` in 1: cancel the current command.
- `pos_clear` in 1: zero the position counters.
- `x_step`, `y_step` out 1: step pulses.
- `x_dir` out 1: 1 = left/negative.
- `y_dir` out 1: 1 = up/negative.
- `pen_down` out 1: servo request.
- `pos_x`, `pos_y` out 32: signed absolute position.
- `busy` out 1: state is not IDLE and not DONE.
- `done` out 1: one-cycle pulse on command completion.

## Operation
- Reset values: all outputs 0, except `cmd_ready` = 1. State is IDLE.
- States and transitions:
  - IDLE to PEN on accept, when `cmd_pen` differs from `pen_down`.
  - IDLE to SETUP on accept otherwise.
  - PEN to SETUP after the settle count expires.
  - SETUP to STEP if n > 0, else to DONE.
  - STEP to DONE after n periods.
  - DONE to IDLE.
- Accept: `cmd_valid & cmd_ready`. The block registers dx, dy and pen; `pen_down` updates on the cycle after accept.
- SETUP:
  - adx = |dx|, ady = |dy|, held as CW-bit unsigned (−2^(CW−1) gives 2^(CW−1)).
  - n = max(adx, ady); the major axis is X when adx ≥ ady.
  - err = 2·minor − major, signed, CW+2 bits.
  - Direction outputs are driven here and held through STEP.
- Each step period:
  - The major axis steps.
  - If err > 0, the minor axis also steps and err −= 2·major.
  - Then err += 2·minor.
- Step pulse: high for the first floor(STEP_DIV/2) cycles of the period, low for the rest.
- Position counters:
  - Updated in the pulse's first high cycle: ±1 per stepping axis, with the sign taken from the dir output.
  - 32-bit two's complement; wraps silently.
- `pos_clear`: zeroes both counters in any state. It wins over a same-cycle update.
- `abort` in PEN, SETUP or STEP:
  - Steps go low the next cycle and the state goes to IDLE.
  - Already-counted steps remain in `pos_*`.
  - `pen_down` holds.
  - No `done` pulse.
  - `abort` is ignored in IDLE and DONE.
- `cmd_valid` while busy: no effect. Command fields need only be stable in the accept cycle.

## Timing
- Accept at cycle T.
- Without a pen change, SETUP is at T+1. Directions are valid at T+2, and the first step pulse rises at T+2.
- With a pen change, the block spends PEN_SETTLE cycles in PEN (T+1 onward), and SETUP follows.
- `done` is high exactly one cycle after the last period ends (T+2+n·STEP_DIV without settle). `cmd_ready` returns the next cycle.
- Back-to-back commands: minimum 3 idle/overhead cycles between the last step period and the next first pulse.
- `reset_n` low mid-move: outputs clear immediately (asynchronously). The position is lost.

## Configuration
- `PLOT_PEN_SETTLE_EN` defined: the PEN state is inserted on any pen change, as above.
- `PLOT_PEN_SETTLE_EN` undefined:
  - No PEN state and no settle counter.
  - `pen_down` updates on the cycle after accept, and motion starts at T+2.
  - The `PEN_SETTLE` parameter is ignored.

## Structure
- Package `plot_pkg` holds:
  - the state enum (IDLE, PEN, SETUP, STEP, DONE);
  - the direction constants (DIR_POS = 0, DIR_NEG = 1);
  - the pen constants (PEN_UP = 0, PEN_DOWN = 1).
- Sub-module `step_timer`:
  - a STEP_DIV period counter that restarts on `start`;
  - outputs `pulse_hi` (first-half phase), `pulse_rise` (first cycle of each period) and `period_end`;
  - shared by both axes.
- The Bresenham error register, the step countdown and the position counters live in the top module.

## Test plan
Bench parameters are STEP_DIV = 4 and PEN_SETTLE = 8 unless stated.
- Reset: assert `reset_n` = 0 mid-move → all outputs 0 at once; after release, `cmd_ready` = 1 and `pos` = (0,0).
- Pure X move: dx = 3, dy = 0, pen = 0 from reset → 3 `x_step` pulses (2 cycles high each), `x_dir` = 0, no `y_step`, `pos_x` = 3, `done` at T+14.
- Diagonal move: dx = −4, dy = 2 → 4 X pulses with `x_dir` = 1; Y pulses on steps 2 and 4 with `y_dir` = 0; final pos = (−4, 2).
- Pen-only command: dx = dy = 0, pen 0→1 → `pen_down` = 1 at T+1, no steps, `done` at T+10. With the macro undefined, `done` at T+2.
- Abort: dx = 10, assert `abort` after the 3rd `x_step` rise → steps low next cycle, `pos_x` = 3, no `done`, `cmd_ready` = 1.
- Clear collision: `pos_clear` in the same cycle as a step rise at pos (5,0) → pos = (0,0); the next step gives (1,0).
